// File: rtl/mealy_pkg.sv
// Shared types and pure functions for the LPT Mealy code observer:
// state/tracker enums, the code map and the fixed next-state function.
package mealy_pkg;

    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2,
        S_D = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TRK_HUNT  = 2'd0,
        TRK_LOCK  = 2'd1,
        TRK_FAULT = 2'd2
    } trk_e;

    localparam logic [2:0] CODE_A0      = 3'b111;
    localparam logic [2:0] CODE_A1      = 3'b101;
    localparam logic [2:0] CODE_B0      = 3'b001;
    localparam logic [2:0] CODE_B1      = 3'b011;
    localparam logic [2:0] CODE_C0      = 3'b000;
    localparam logic [2:0] CODE_C1      = 3'b100;
    localparam logic [2:0] CODE_D       = 3'b110;
    localparam logic [2:0] CODE_ILLEGAL = 3'b010;

    typedef struct packed {
        logic   legal;
        state_e state;
        logic   in_bit;
        logic   in_known;
    } dec_t;

    function automatic dec_t code_to_state_in(input logic [2:0] code);
        dec_t d;
        d = '{legal: 1'b1, state: S_A, in_bit: 1'b0, in_known: 1'b1};
        case (code)
            CODE_A0: d.state = S_A;
            CODE_A1: begin d.state = S_A; d.in_bit = 1'b1; end
            CODE_B0: d.state = S_B;
            CODE_B1: begin d.state = S_B; d.in_bit = 1'b1; end
            CODE_C0: d.state = S_C;
            CODE_C1: begin d.state = S_C; d.in_bit = 1'b1; end
            // Sd emits the same code for either input, so the input is lost.
            CODE_D:  begin d.state = S_D; d.in_known = 1'b0; end
            CODE_ILLEGAL: begin d.legal = 1'b0; d.in_known = 1'b0; end
            default: begin d.legal = 1'b0; d.in_known = 1'b0; end
        endcase
        return d;
    endfunction

    function automatic state_e next_state(input state_e s, input logic in_bit);
        case (s)
            S_A:     return in_bit ? S_C : S_B;
            S_B:     return in_bit ? S_D : S_C;
            S_C:     return in_bit ? S_A : S_D;
            default: return S_A;
        endcase
    endfunction

endpackage

// File: rtl/mealy_code_dec.sv
// Combinational decode of one 3-bit Mealy code into legality, state and input.
module mealy_code_dec
    import mealy_pkg::*;
(
    input  logic [2:0] code_i,
    output logic       legal_o,
    output logic [1:0] state_o,
    output logic       in_o,
    output logic       in_known_o
);

    dec_t dec;

    assign dec        = code_to_state_in(code_i);
    assign legal_o    = dec.legal;
    assign state_o    = dec.state;
    assign in_o       = dec.in_bit;
    assign in_known_o = dec.in_known;

endmodule

// File: rtl/mealy_observer.sv
// Receiver-side observer: registers incoming codes, decodes them, tracks the
// stream against the LPT next-state function and counts sequence violations.
module mealy_observer
    import mealy_pkg::*;
#(
    parameter int RELOCK = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [2:0]       code,
    output logic             dec_valid,
    output logic [1:0]       dec_state,
    output logic             dec_in,
    output logic             dec_in_known,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] RELOCK_C = 4'(RELOCK);

    logic             in_valid_q;
    logic [2:0]       in_code_q;
    trk_e             fsm_q, fsm_d;
    state_e           pred_q, pred_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             in_q, in_d;
    logic             known_q, known_d;
    logic             dec_valid_q, locked_q, err_pulse_q;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             viol;

    logic       w_legal, w_in, w_known;
    logic [1:0] w_state;
    logic       match;

    mealy_code_dec u_dec (
        .code_i     (in_code_q),
        .legal_o    (w_legal),
        .state_o    (w_state),
        .in_o       (w_in),
        .in_known_o (w_known)
    );

    assign match = (w_state == pred_q);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        fsm_d       = fsm_q;
        pred_d      = pred_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        in_d        = in_q;
        known_d     = known_q;
        viol        = 1'b0;
        if (in_valid_q) begin
            if (w_legal) begin
                state_d = w_state;
                in_d    = w_in;
                known_d = w_known;
                pred_d  = next_state(state_e'(w_state), w_in);
            end
            case (fsm_q)
                TRK_HUNT: begin
                    if (w_legal) fsm_d = TRK_LOCK;
                    else         viol  = 1'b1;
                end
                TRK_LOCK: begin
                    if (!(w_legal && match)) begin
                        viol  = 1'b1;
                        fsm_d = TRK_FAULT;
                        cnt_d = 4'd0;
                    end
                end
                TRK_FAULT: begin
                    // A mismatch here restarts the run at 1: this code is its first member.
                    if (!w_legal) begin
                        viol  = 1'b1;
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = match ? cnt_q + 4'd1 : 4'd1;
                        if (cnt_d == RELOCK_C) begin
                            fsm_d = TRK_LOCK;
                            cnt_d = 4'd0;
                        end
                    end
                end
                default: fsm_d = TRK_HUNT;
            endcase
        end
        err_count_d = (viol && (err_count_q != '1)) ? err_count_q + 1'b1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            in_valid_q  <= 1'b0;
            in_code_q   <= 3'd0;
            fsm_q       <= TRK_HUNT;
            pred_q      <= S_A;
            cnt_q       <= 4'd0;
            state_q     <= 2'd0;
            in_q        <= 1'b0;
            known_q     <= 1'b0;
            dec_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            in_valid_q  <= code_valid;
            in_code_q   <= code;
            fsm_q       <= fsm_d;
            pred_q      <= pred_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            in_q        <= in_d;
            known_q     <= known_d;
            dec_valid_q <= in_valid_q;
            locked_q    <= (fsm_d == TRK_LOCK);
            err_pulse_q <= viol;
            err_count_q <= err_count_d;
        end
    end

    assign dec_valid    = dec_valid_q;
    assign dec_state    = state_q;
    assign dec_in       = in_q;
    assign dec_in_known = known_q;
    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_mealy_observer.sv
// Scoreboard bench for mealy_observer: a reference model queues expected
// outputs per accepted code; a negedge monitor pops and compares them.
module tb_mealy_observer;

    localparam int RELOCK = 2;

    logic       clk = 1'b0;
    logic       reset, code_valid;
    logic [2:0] code;
    logic       dec_valid, dec_in, dec_in_known, locked, err_pulse;
    logic [1:0] dec_state;
    logic [7:0] err_count;

    logic       cv2;
    logic [2:0] code2;
    logic       dv2, din2, dk2, lk2, ep2;
    logic [1:0] ds2;
    logic [1:0] ec2;

    always #5 clk = ~clk;

    mealy_observer #(.RELOCK(RELOCK), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
        .dec_valid(dec_valid), .dec_state(dec_state), .dec_in(dec_in),
        .dec_in_known(dec_in_known), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    mealy_observer #(.RELOCK(RELOCK), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .code_valid(cv2), .code(code2),
        .dec_valid(dv2), .dec_state(ds2), .dec_in(din2),
        .dec_in_known(dk2), .locked(lk2), .err_pulse(ep2),
        .err_count(ec2)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       in_b;
        logic       known;
        logic       lk;
        logic       ep;
        logic [7:0] ec;
    } exp_t;

    exp_t obs;
    assign obs = {dec_state, dec_in, dec_in_known, locked, err_pulse, err_count};

    exp_t sbq[$];
    exp_t hold;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    // Reference model state: 0=HUNT 1=LOCK 2=FAULT.
    int         m_fsm, m_cnt;
    logic [1:0] m_pred, m_st;
    logic       m_in, m_known;
    logic [7:0] m_err;
    logic [1:0] nxt_tab [8] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};

    task automatic model_reset();
        m_fsm = 0; m_cnt = 0; m_pred = 2'd0; m_st = 2'd0;
        m_in = 1'b0; m_known = 1'b0; m_err = 8'd0;
        hold = '0;
        sbq.delete();
    endtask

    task automatic model_step(input logic [2:0] c);
        logic       lg, b, k, viol;
        logic [1:0] s;
        exp_t       e;
        lg = 1'b1; b = 1'b0; k = 1'b1; s = 2'd0; viol = 1'b0;
        case (c)
            3'b111: s = 2'd0;
            3'b101: begin s = 2'd0; b = 1'b1; end
            3'b001: s = 2'd1;
            3'b011: begin s = 2'd1; b = 1'b1; end
            3'b000: s = 2'd2;
            3'b100: begin s = 2'd2; b = 1'b1; end
            3'b110: begin s = 2'd3; k = 1'b0; end
            default: begin lg = 1'b0; k = 1'b0; end
        endcase
        if (m_fsm == 0) begin
            if (lg) m_fsm = 1; else viol = 1'b1;
        end else if (m_fsm == 1) begin
            if (!lg || s != m_pred) begin viol = 1'b1; m_fsm = 2; m_cnt = 0; end
        end else begin
            if (!lg) begin
                viol = 1'b1; m_cnt = 0;
            end else begin
                m_cnt = (s == m_pred) ? m_cnt + 1 : 1;
                if (m_cnt >= RELOCK) begin m_fsm = 1; m_cnt = 0; end
            end
        end
        if (lg) begin
            m_st = s; m_in = b; m_known = k; m_pred = nxt_tab[{s, b}];
        end
        if (viol && m_err != 8'hFF) m_err = m_err + 8'd1;
        e = '{st: m_st, in_b: m_in, known: m_known, lk: (m_fsm == 1), ep: viol, ec: m_err};
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            n_vec++;
            if (dec_valid) begin
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_dec_valid: got outputs %b with empty scoreboard", obs);
                end else begin
                    e = sbq.pop_front();
                    if (obs !== e) begin
                        n_err++;
                        $display("FAIL sb_decode: got %b want %b (st,in,known,lk,ep,ec)", obs, e);
                    end
                    hold = e;
                    hold.ep = 1'b0;
                end
            end else if (obs !== hold) begin
                n_err++;
                $display("FAIL hold_idle: got %b want %b (st,in,known,lk,ep,ec)", obs, hold);
            end
        end
    end

    task automatic apply(input logic [2:0] c);
        @(posedge clk); #1;
        code_valid = 1'b1; code = c;
        model_step(c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; code_valid = 1'b0; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; code_valid = 1'b0; cv2 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; code_valid = 1'b0; code = 3'd0; cv2 = 1'b0; code2 = 3'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        n_vec++;
        if ({dec_valid, obs} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {dec_valid, obs});
        end
        n_vec++;
        if ({dv2, ds2, din2, dk2, lk2, ep2, ec2} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_outputs_w2: got %b want 0", {dv2, ds2, din2, dk2, lk2, ep2, ec2});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_sequence();
        do_reset();
        apply(3'b111); apply(3'b001); apply(3'b000); apply(3'b110); apply(3'b101);
        idle(4);
        n_vec++;
        if ({err_count, locked, dec_state, dec_in, dec_in_known} !== {8'd0, 1'b1, 2'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL seq_final: got ec=%0d lk=%b st=%0d in=%b known=%b want ec=0 lk=1 st=0 in=1 known=1",
                     err_count, locked, dec_state, dec_in, dec_in_known);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        apply(3'b111); apply(3'b100);
        idle(4);
        n_vec++;
        if ({locked, err_count} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL mismatch_fault: got lk=%b ec=%0d want lk=0 ec=1", locked, err_count);
        end
        apply(3'b110); apply(3'b101);
        idle(4);
        n_vec++;
        if ({locked, err_count} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL relock: got lk=%b ec=%0d want lk=1 ec=1", locked, err_count);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        apply(3'b010); idle(4);
        n_vec++;
        if ({err_count, locked, dec_state, dec_in_known} !== {8'd1, 1'b0, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL illegal_hunt: got ec=%0d lk=%b st=%0d known=%b want ec=1 lk=0 st=0 known=0",
                     err_count, locked, dec_state, dec_in_known);
        end
        apply(3'b001); apply(3'b010); idle(4);
        n_vec++;
        if ({err_count, locked, dec_state, dec_in_known} !== {8'd2, 1'b0, 2'd1, 1'b1}) begin
            n_err++;
            $display("FAIL illegal_lock: got ec=%0d lk=%b st=%0d known=%b want ec=2 lk=0 st=1 known=1",
                     err_count, locked, dec_state, dec_in_known);
        end
        apply(3'b010); idle(4);
        n_vec++;
        if ({err_count, locked, dec_state} !== {8'd3, 1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL illegal_fault: got ec=%0d lk=%b st=%0d want ec=3 lk=0 st=1",
                     err_count, locked, dec_state);
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 5; i++) begin
            int         t;
            logic [1:0] want;
            want = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
            @(posedge clk); #1; cv2 = 1'b1; code2 = 3'b010;
            @(posedge clk); #1; cv2 = 1'b0;
            t = 0;
            while (dv2 !== 1'b1 && t < 4) begin @(negedge clk); t++; end
            n_vec++;
            if (dv2 !== 1'b1) begin
                n_err++;
                $display("FAIL sat_timeout[%0d]: dec_valid stayed %b want 1", i, dv2);
            end else if ({ep2, ec2} !== {1'b1, want}) begin
                n_err++;
                $display("FAIL sat_count[%0d]: got ep=%b ec=%0d want ep=1 ec=%0d", i, ep2, ec2, want);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        apply(3'b111); idle(3);
        n_vec++;
        if ({dec_valid, err_pulse, locked, dec_state} !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL gap_hold: got dv=%b ep=%b lk=%b st=%0d want dv=0 ep=0 lk=1 st=0",
                     dec_valid, err_pulse, locked, dec_state);
        end
        idle(3);
        apply(3'b001); idle(4);
        n_vec++;
        if ({locked, err_count, dec_state} !== {1'b1, 8'd0, 2'd1}) begin
            n_err++;
            $display("FAIL gap_lock: got lk=%b ec=%0d st=%0d want lk=1 ec=0 st=1", locked, err_count, dec_state);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        apply(3'b001); apply(3'b010); apply(3'b000);
        @(posedge clk); #1;
        reset = 1'b1; code_valid = 1'b1; code = 3'b110;
        @(posedge clk); #1;
        reset = 1'b0; code_valid = 1'b0;
        model_reset();
        n_vec++;
        if ({dec_valid, obs} !== 15'd0) begin
            n_err++;
            $display("FAIL midreset_zero: got %b want 0", {dec_valid, obs});
        end
        idle(3);
        apply(3'b101); idle(4);
        n_vec++;
        if ({err_count, locked, dec_state, dec_in} !== {8'd0, 1'b1, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL midreset_first: got ec=%0d lk=%b st=%0d in=%b want ec=0 lk=1 st=0 in=1",
                     err_count, locked, dec_state, dec_in);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mismatch();
        test_illegal();
        test_err_saturate();
        test_gaps();
        test_reset_midstream();
        for (int t = 0; t < 10 && sbq.size() != 0; t++) @(posedge clk);
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected outputs never produced, want 0", sbq.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
